// File: rtl/mac_mdc_d_packer.sv
// Packs saturated/truncated MAC results into DATA_W output words, little-endian lanes,
// with TLAST at frame end and a single registered output stage.
module mac_mdc_d_packer #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 12
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              d_TVALID,
  output logic              d_TREADY,
  input  logic [DATA_W-1:0] d_TDATA,
  output logic              o_TVALID,
  input  logic              o_TREADY,
  output logic [DATA_W-1:0] o_TDATA,
  output logic              o_TLAST,
  input  logic [CNT_W-1:0]  reg_len,
  input  logic              reg_sat_en,
  input  logic              reg_signed,
  input  logic              reg_clear,
  output logic              flag_sat
);

  localparam int PACK   = DATA_W / OUT_W;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
  localparam logic signed [DATA_W-1:0] S_MAX = DATA_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [DATA_W-1:0] S_MIN = -S_MAX - DATA_W'(1);
  localparam logic signed [DATA_W-1:0] U_MAX = DATA_W'((64'd1 << OUT_W) - 64'd1);

  logic [DATA_W-1:0]        pack;
  logic [LANE_W-1:0]        lane;
  logic [CNT_W-1:0]         elem_cnt;
  logic [CNT_W-1:0]         len_m1;
  logic signed [DATA_W-1:0] x;
  logic [OUT_W-1:0]         conv;
  logic                     clipped;
  logic                     frame_end;
  logic                     close;
  logic                     out_free;
  logic                     in_beat;
  logic [DATA_W-1:0]        new_word;

  assign x = signed'(d_TDATA);

  always_comb begin
    conv    = d_TDATA[OUT_W-1:0];
    clipped = 1'b0;
    if (reg_sat_en) begin
      if (reg_signed) begin
        if (x > S_MAX) begin
          conv    = S_MAX[OUT_W-1:0];
          clipped = 1'b1;
        end else if (x < S_MIN) begin
          conv    = S_MIN[OUT_W-1:0];
          clipped = 1'b1;
        end
      end else begin
        if (x < 0) begin
          conv    = '0;
          clipped = 1'b1;
        end else if (x > U_MAX) begin
          conv    = U_MAX[OUT_W-1:0];
          clipped = 1'b1;
        end
      end
    end
  end

  // A length of zero behaves as a one-element frame.
  assign len_m1    = (reg_len == '0) ? '0 : reg_len - CNT_W'(1);
  assign frame_end = (elem_cnt == len_m1);
  assign close     = (lane == LAST_LANE) | frame_end;

  // Handshake: a beat happens on a rising edge where VALID & READY are both high.
  // Only a closing beat depends on the output register being free; o_TREADY feeds
  // d_TREADY combinationally so a draining word can be replaced in the same cycle.
  assign out_free = ~o_TVALID | o_TREADY;
  assign d_TREADY = ~ap_rst & ~reg_clear & (~close | out_free);
  assign in_beat  = d_TVALID & d_TREADY;

  // Lanes above the current one are always zero because pack is cleared on close.
  assign new_word = pack | (DATA_W'(conv) << (lane * OUT_W));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      pack     <= '0;
      lane     <= '0;
      elem_cnt <= '0;
      flag_sat <= 1'b0;
      o_TVALID <= 1'b0;
      o_TDATA  <= '0;
      o_TLAST  <= 1'b0;
    end else begin
      if (reg_clear) begin
        pack     <= '0;
        lane     <= '0;
        elem_cnt <= '0;
        flag_sat <= 1'b0;
      end else if (in_beat) begin
        if (clipped) flag_sat <= 1'b1;
        if (close) begin
          pack     <= '0;
          lane     <= '0;
          elem_cnt <= frame_end ? '0 : elem_cnt + CNT_W'(1);
        end else begin
          pack     <= new_word;
          lane     <= lane + LANE_W'(1);
          elem_cnt <= elem_cnt + CNT_W'(1);
        end
      end

      if (in_beat && close) begin
        o_TVALID <= 1'b1;
        o_TDATA  <= new_word;
        o_TLAST  <= frame_end;
      end else if (o_TREADY) begin
        o_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_mdc_d_packer.sv
// Bench for mac_mdc_d_packer: directed vectors, a frame-level reference model with an
// expected-word queue compared every cycle, and literal checks on the collected words.
module tb_mac_mdc_d_packer;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 12;
  localparam int PACK   = DATA_W / OUT_W;

  logic              ap_clk;
  logic              ap_rst;
  logic              d_TVALID;
  logic              d_TREADY;
  logic [DATA_W-1:0] d_TDATA;
  logic              o_TVALID;
  logic              o_TREADY;
  logic [DATA_W-1:0] o_TDATA;
  logic              o_TLAST;
  logic [CNT_W-1:0]  reg_len;
  logic              reg_sat_en;
  logic              reg_signed;
  logic              reg_clear;
  logic              flag_sat;

  mac_mdc_d_packer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .d_TVALID  (d_TVALID),
    .d_TREADY  (d_TREADY),
    .d_TDATA   (d_TDATA),
    .o_TVALID  (o_TVALID),
    .o_TREADY  (o_TREADY),
    .o_TDATA   (o_TDATA),
    .o_TLAST   (o_TLAST),
    .reg_len   (reg_len),
    .reg_sat_en(reg_sat_en),
    .reg_signed(reg_signed),
    .reg_clear (reg_clear),
    .flag_sat  (flag_sat)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: expected words as {last, data}
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W:0]   got_q[$];
  int                m_word_n = 0;
  int                m_frame_n = 0;
  logic [DATA_W-1:0] m_acc = '0;
  logic              m_flag = 1'b0;
  int                len_e;
  logic              close_m;
  logic [OUT_W-1:0]  m_b;
  logic              m_clip;

  function automatic void conv_model(input logic [DATA_W-1:0] d, input logic sat, input logic sgn,
                                     output logic [OUT_W-1:0] b, output logic clip);
    longint xv = longint'(signed'(d));
    longint v  = xv;
    longint lo = sgn ? -(longint'(1) << (OUT_W - 1)) : 0;
    longint hi = sgn ? (longint'(1) << (OUT_W - 1)) - 1 : (longint'(1) << OUT_W) - 1;
    if (!sat) begin
      b    = d[OUT_W-1:0];
      clip = 1'b0;
    end else begin
      if (xv < lo) v = lo;
      else if (xv > hi) v = hi;
      b    = v[OUT_W-1:0];
      clip = (v != xv);
    end
  endfunction

  // scoreboard: compare on the falling edge, then advance the model with this cycle's beats
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      exp_q.delete();
      m_word_n  = 0;
      m_frame_n = 0;
      m_acc     = '0;
      m_flag    = 1'b0;
    end else begin
      len_e   = (reg_len == 0) ? 1 : int'(reg_len);
      close_m = (m_word_n == PACK - 1) || (m_frame_n == len_e - 1);
      chk("d_tready", 64'(d_TREADY), 64'(!reg_clear && (!close_m || exp_q.size() == 0 || o_TREADY)));
      chk("o_tvalid", 64'(o_TVALID), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("o_word", 64'({o_TLAST, o_TDATA}), 64'(exp_q[0]));
      chk("flag_sat", 64'(flag_sat), 64'(m_flag));
      if (o_TVALID && o_TREADY) begin
        got_q.push_back({o_TLAST, o_TDATA});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (d_TVALID && d_TREADY) begin
        conv_model(d_TDATA, reg_sat_en, reg_signed, m_b, m_clip);
        if (m_clip) m_flag = 1'b1;
        m_acc = m_acc | (DATA_W'(m_b) << (OUT_W * m_word_n));
        m_word_n++;
        m_frame_n++;
        if (m_frame_n == len_e || m_word_n == PACK) begin
          exp_q.push_back({m_frame_n == len_e, m_acc});
          if (m_frame_n == len_e) m_frame_n = 0;
          m_word_n = 0;
          m_acc    = '0;
        end
      end
      if (reg_clear) begin
        m_word_n  = 0;
        m_frame_n = 0;
        m_acc     = '0;
        m_flag    = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (rand_rdy) o_TREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    bit taken = 1'b0;
    d_TVALID = 1'b1;
    d_TDATA  = v;
    for (int n = 0; n < 200 && !taken; n++) begin
      @(negedge ap_clk);
      taken = d_TREADY;
      tick();
    end
    if (!taken) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    d_TVALID = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    bit done = 1'b0;
    d_TVALID = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (exp_q.size() == 0 && !o_TVALID) done = 1'b1;
      else tick();
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_clear();
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
  endtask

  function automatic logic [DATA_W:0] got(input int i);
    if (got_q.size() > i) return got_q[i];
    return 'x;
  endfunction

  int n_el;
  int n_last;
  int lens[10] = '{0, 1, 2, 3, 4, 5, 7, 9, 13, 4095};

  initial begin
    ap_rst     = 1'b1;
    d_TVALID   = 1'b0;
    d_TDATA    = '0;
    o_TREADY   = 1'b1;
    reg_len    = 12'd4;
    reg_sat_en = 1'b1;
    reg_signed = 1'b1;
    reg_clear  = 1'b0;
    repeat (3) tick();
    chk("rst_d_tready", 64'(d_TREADY), 64'd0);
    chk("rst_o_tvalid", 64'(o_TVALID), 64'd0);
    chk("rst_o_tdata",  64'(o_TDATA),  64'd0);
    chk("rst_o_tlast",  64'(o_TLAST),  64'd0);
    chk("rst_flag_sat", 64'(flag_sat), 64'd0);
    ap_rst = 1'b0;
    tick();

    // T1: simple frame, one-cycle latency
    got_q.delete();
    send(1); send(2); send(3); send(4);
    chk("t1_latency", 64'(o_TVALID), 64'd1);
    drain();
    chk("t1_count", 64'(got_q.size()), 64'd1);
    chk("t1_word", 64'(got(0)), 64'h1_0403_0201);
    chk("t1_flag", 64'(flag_sat), 64'd0);

    // T2: signed saturation, partial final word
    got_q.delete();
    reg_len = 12'd6;
    send(300); send(-300); send(5); send(-1); send(127); send(-128);
    drain();
    chk("t2_word0", 64'(got(0)), 64'h0_FF05_807F);
    chk("t2_word1", 64'(got(1)), 64'h1_0000_807F);
    chk("t2_flag", 64'(flag_sat), 64'd1);
    pulse_clear();
    chk("t2_flag_cleared", 64'(flag_sat), 64'd0);

    // T3: unsigned saturation vs truncation
    got_q.delete();
    reg_len = 12'd4;
    reg_signed = 1'b0;
    send(-5); send(256); send(255); send(0);
    drain();
    chk("t3_sat_word", 64'(got(0)), 64'h1_00FF_FF00);
    chk("t3_sat_flag", 64'(flag_sat), 64'd1);
    pulse_clear();
    got_q.delete();
    reg_sat_en = 1'b0;
    send(-5); send(256); send(255); send(0);
    drain();
    chk("t3_trunc_word", 64'(got(0)), 64'h1_00FF_00FB);
    chk("t3_trunc_flag", 64'(flag_sat), 64'd0);
    reg_sat_en = 1'b1;
    reg_signed = 1'b1;

    // T4: backpressure on the second closing beat
    got_q.delete();
    reg_len = 12'd8;
    o_TREADY = 1'b0;
    for (int i = 1; i <= 7; i++) send(i);
    d_TVALID = 1'b1;
    d_TDATA  = 8;
    for (int i = 0; i < 7; i++) begin
      @(negedge ap_clk);
      chk("t4_stall", 64'(d_TREADY), 64'd0);
      chk("t4_hold", 64'(o_TDATA), 64'h0403_0201);
      tick();
    end
    o_TREADY = 1'b1;
    send(8);
    drain();
    chk("t4_word0", 64'(got(0)), 64'h0_0403_0201);
    chk("t4_word1", 64'(got(1)), 64'h1_0807_0605);

    // T5: random handshakes across frame lengths
    rand_rdy = 1'b1;
    foreach (lens[k]) begin
      got_q.delete();
      reg_len = CNT_W'(lens[k]);
      n_el = (lens[k] == 0) ? 1 : lens[k];
      for (int i = 0; i < n_el; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if ($urandom_range(0, 1) == 1) send($urandom);
        else send(DATA_W'($urandom_range(0, 600)) - DATA_W'(300));
      end
      drain();
      n_last = 0;
      foreach (got_q[j]) if (got_q[j][DATA_W]) n_last++;
      chk("t5_words", 64'(got_q.size()), 64'((n_el + PACK - 1) / PACK));
      chk("t5_one_last", 64'(n_last), 64'd1);
      chk("t5_final_last", 64'(got(got_q.size() - 1) >> DATA_W), 64'd1);
    end
    rand_rdy = 1'b0;
    o_TREADY = 1'b1;
    tick();

    // T6: clear drops a partial word and the sticky flag
    pulse_clear();
    got_q.delete();
    reg_len = 12'd4;
    send(1000); send(7);
    idle(1);
    chk("t6_flag_set", 64'(flag_sat), 64'd1);
    pulse_clear();
    chk("t6_flag_cleared", 64'(flag_sat), 64'd0);
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    drain();
    chk("t6_count", 64'(got_q.size()), 64'd1);
    chk("t6_word", 64'(got(0)), 64'h1_4433_2211);
    chk("t6_flag", 64'(flag_sat), 64'd0);

    // reset mid-frame with a pending word
    got_q.delete();
    o_TREADY = 1'b0;
    send(1000); send(2); send(3); send(4); send(5); send(6);
    d_TVALID = 1'b0;
    ap_rst = 1'b1;
    #1;
    chk("mrst_o_tvalid", 64'(o_TVALID), 64'd0);
    chk("mrst_o_tdata",  64'(o_TDATA),  64'd0);
    chk("mrst_o_tlast",  64'(o_TLAST),  64'd0);
    chk("mrst_flag",     64'(flag_sat), 64'd0);
    chk("mrst_d_tready", 64'(d_TREADY), 64'd0);
    tick();
    ap_rst = 1'b0;
    o_TREADY = 1'b1;
    tick();
    send(9); send(10); send(11); send(12);
    drain();
    chk("mrst_count", 64'(got_q.size()), 64'd1);
    chk("mrst_word", 64'(got(0)), 64'h1_0C0B_0A09);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
